// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - requester/response bus between datapath engines and the multiplier arbiter
interface mult_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [2*W-1:0]    rsp_y;
    logic              rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_err
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one sequential multiplier with start/done watchdog
module mult_share_arbiter #(
    parameter int NREQ      = 4,
    parameter int W         = 16,
    parameter int TIMEOUT   = 40,
    parameter int DONE_MASK = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_share_arbiter_if.slave bus,
    output logic                mul_start_o,
    output logic [W-1:0]        mul_a_o,
    output logic [W-1:0]        mul_b_o,
    input  logic                mul_done_i,
    input  logic [2*W-1:0]      mul_y_i,
    output logic                busy_o,
    output logic [15:0]         ops_cnt_o
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_grant_q;
    logic [GW-1:0]   owner_q;
    logic [W-1:0]    a_q, b_q;
    logic [CW-1:0]   run_cnt_q;
    logic [2*W-1:0]  rsp_y_q;
    logic            err_q;
    logic [15:0]     ops_cnt_q;

    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [GW:0]     probe;
    logic            done_ok;
    logic            tmo;
    logic            rsp_hs;

    // Scan from the requester after last_grant; iterating downward keeps the nearest hit.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            probe = {1'b0, last_grant_q} + (GW+1)'(k);
            if (probe >= (GW+1)'(NREQ)) probe = probe - (GW+1)'(NREQ);
            if (bus.req_valid[probe[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = probe[GW-1:0];
            end
        end
    end

    // A done seen in the first DONE_MASK cycles may be left over from the previous operation.
    assign done_ok = mul_done_i && (run_cnt_q >= CW'(DONE_MASK));
    assign tmo     = (run_cnt_q == CW'(TIMEOUT - 1));
    assign rsp_hs  = bus.rsp_ready[owner_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found)      state_d = RUN;
            RUN:     if (done_ok || tmo) state_d = RESP;
            RESP:    if (rsp_hs)         state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (state_q == IDLE && win_found) bus.req_ready[win_idx] = 1'b1;
        if (state_q == RESP)              bus.rsp_valid[owner_q] = 1'b1;
        bus.rsp_y   = rsp_y_q;
        bus.rsp_err = err_q && (state_q == RESP);
        mul_start_o = (state_q == RUN);
        mul_a_o     = a_q;
        mul_b_o     = b_q;
        busy_o      = (state_q != IDLE);
        ops_cnt_o   = ops_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GW'(NREQ - 1);
            owner_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            run_cnt_q    <= '0;
            rsp_y_q      <= '0;
            err_q        <= 1'b0;
            ops_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        a_q          <= bus.req_a[win_idx*W +: W];
                        b_q          <= bus.req_b[win_idx*W +: W];
                        owner_q      <= win_idx;
                        last_grant_q <= win_idx;
                        run_cnt_q    <= '0;
                    end
                end
                RUN: begin
                    run_cnt_q <= run_cnt_q + 1'b1;
                    if (done_ok) begin
                        rsp_y_q <= mul_y_i;
                        err_q   <= 1'b0;
                    end else if (tmo) begin
                        rsp_y_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) ops_cnt_q <= ops_cnt_q + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - scoreboard bench for mult_share_arbiter with a shift-add multiplier model
module tb_mult_share_arbiter;
    localparam int NREQ      = 4;
    localparam int W         = 16;
    localparam int TIMEOUT   = 40;
    localparam int DONE_MASK = 2;
    localparam int NLAT      = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

    logic           mul_start;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_done;
    logic [2*W-1:0] mul_y;
    logic           busy;
    logic [15:0]    ops_cnt;

    mult_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT), .DONE_MASK(DONE_MASK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .mul_start_o (mul_start),
        .mul_a_o     (mul_a),
        .mul_b_o     (mul_b),
        .mul_done_i  (mul_done),
        .mul_y_i     (mul_y),
        .busy_o      (busy),
        .ops_cnt_o   (ops_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Multiplier model: 0 = done after NLAT cycles, 1 = never done, 2 = stale done at start then normal
    int mode = 0;
    int mcnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          mcnt <= 0;
        else if (!mul_start) mcnt <= 0;
        else                 mcnt <= mcnt + 1;
    end
    always @* begin
        mul_done = mul_start && (((mode == 0 || mode == 2) && mcnt >= NLAT) ||
                                 (mode == 2 && mcnt < DONE_MASK));
        mul_y    = (mode == 2 && mcnt < DONE_MASK) ? 32'hDEAD_BEEF : (32'(mul_a) * 32'(mul_b));
    end

    typedef struct {
        int          owner;
        logic [31:0] y;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   cyc = 0;
    logic rsp_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int   g;
        exp_t e;
        if (!rst_n) begin
            rsp_seen <= 1'b0;
        end else begin
            if ((bus.req_valid & bus.req_ready) != '0) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
                check("grant_onehot", $countones(bus.req_ready), 1);
                grants.push_back(g);
                e.owner = g;
                if (mode == 1) begin
                    e.y   = 32'h0;
                    e.err = 1'b1;
                    e.due = cyc + 1 + TIMEOUT;
                end else begin
                    e.y   = 32'(bus.req_a[g*W +: W]) * 32'(bus.req_b[g*W +: W]);
                    e.err = 1'b0;
                    e.due = cyc + 2 + NLAT;
                end
                sb.push_back(e);
            end
            if (bus.rsp_valid != '0 && !rsp_seen) begin
                rsp_seen <= 1'b1;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_owner", 32'(bus.rsp_valid), 32'(1 << e.owner));
                    check("rsp_y", bus.rsp_y, e.y);
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    check("rsp_latency", cyc, e.due);
                end
            end else if (bus.rsp_valid == '0) begin
                rsp_seen <= 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant(input int g);
        int k = 0;
        #1;
        while (!bus.req_ready[g] && k < 200) begin
            step(1);
            k++;
        end
        check($sformatf("grant_%0d", g), 32'(bus.req_ready[g]), 32'h1);
        step(1);
        bus.req_valid[g] = 1'b0;
    endtask

    task automatic issue(input int g, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[g*W +: W] = a;
        bus.req_b[g*W +: W] = b;
        bus.req_valid[g]    = 1'b1;
        wait_grant(g);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 200) begin
            step(1);
            k++;
        end
        check(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [31:0] y0;
        logic [15:0] cnt0;
        int          start;
        int          k;
        int          rr_exp[5];

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;
        rr_exp        = '{0, 1, 2, 3, 0};

        step(3);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_y", bus.rsp_y, 32'h0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        check("rst_mul_start", 32'(mul_start), 32'h0);
        check("rst_mul_ab", {mul_a, mul_b}, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ops_cnt", 32'(ops_cnt), 32'h0);
        rst_n = 1'b1;
        step(2);

        // Single operation from requester 0
        issue(0, 16'd3, 16'd5);
        wait_idle("single_idle");
        check("single_ops_cnt", 32'(ops_cnt), 32'd1);

        // Full-scale and zero operands on requester 3
        issue(3, 16'hFFFF, 16'hFFFF);
        wait_idle("full_idle");
        issue(3, 16'h0000, 16'h1234);
        wait_idle("zero_idle");

        // Round robin with all requesters held valid
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = 16'(16'h0100 + i * 16'h0111);
            bus.req_b[i*W +: W] = 16'(16'h0020 + i * 3);
        end
        start = grants.size();
        bus.req_valid = '1;
        k = 0;
        while (grants.size() < start + 5 && k < 400) begin
            step(1);
            k++;
        end
        bus.req_valid = '0;
        wait_idle("rr_idle");
        check("rr_count", grants.size() - start, 5);
        for (int i = 0; i < 5; i++)
            if (start + i < grants.size())
                check($sformatf("rr_order_%0d", i), grants[start + i], rr_exp[i]);

        // Backpressure on requester 0 while requester 1 waits
        bus.rsp_ready[0] = 1'b0;
        issue(0, 16'd7, 16'd9);
        k = 0;
        while (!bus.rsp_valid[0] && k < 100) begin
            step(1);
            k++;
        end
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        bus.req_a[1*W +: W] = 16'd11;
        bus.req_b[1*W +: W] = 16'd13;
        bus.req_valid[1]    = 1'b1;
        y0   = bus.rsp_y;
        cnt0 = ops_cnt;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
            check("bp_hold_y", bus.rsp_y, y0);
            check("bp_mul_start", 32'(mul_start), 32'h0);
            check("bp_no_ready", 32'(bus.req_ready), 32'h0);
            check("bp_ops_cnt", 32'(ops_cnt), 32'(cnt0));
        end
        bus.rsp_ready[0] = 1'b1;
        step(1);
        check("bp_ops_inc", 32'(ops_cnt), 32'(cnt0 + 16'd1));
        wait_grant(1);
        wait_idle("bp_idle");

        // Watchdog timeout
        mode = 1;
        issue(2, 16'd5, 16'd6);
        wait_idle("tmo_idle");

        // Stale done at the start of RUN must be ignored
        mode = 2;
        issue(1, 16'h1111, 16'h2222);
        wait_idle("stale_idle");
        mode = 0;

        // Reset in the middle of RUN
        mode = 1;
        issue(0, 16'd21, 16'd22);
        step(4);
        rst_n = 1'b0;
        #1;
        check("rstmid_mul_start", 32'(mul_start), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rstmid_ops_cnt", 32'(ops_cnt), 32'h0);
        sb.delete();
        step(2);
        rst_n = 1'b1;
        mode = 0;
        step(1);
        issue(0, 16'd12, 16'd13);
        wait_idle("post_rst_idle");
        check("post_rst_ops_cnt", 32'(ops_cnt), 32'd1);
        step(2);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin scheduler that shares one sequential shift-add 16x16 multiplier among NREQ requesters. Each requester hands over an operand pair with a valid/ready handshake. The block sequences the multiplier's start/done protocol and guards it with a watchdog timeout. It returns the 32-bit product, or an error flag, to the originating requester. It sits between the requesting datapath engines and the single multiplier instance.

## Interface

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 16, operand width; product width is 2*W
- TIMEOUT, 40, maximum RUN cycles allowed before the operation is aborted
- DONE_MASK, 2, number of initial RUN cycles during which mul_done is ignored

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  one-hot grant/accept; the handshake completes when req_valid[i] and req_ready[i] are both high
- req_a  in  NREQ*W  multiplicands, requester i in bits [i*W +: W]
- req_b  in  NREQ*W  multipliers, same packing as req_a
- rsp_valid  out  NREQ  one-hot response valid
- rsp_ready  in  NREQ  per-requester response accept
- rsp_y  out  2*W  product; shared by all requesters and meaningful only with rsp_valid
- rsp_err  out  1  high with rsp_valid when the operation timed out
- mul_start  out  1  multiplier enable; held high for the whole operation
- mul_a, mul_b  out  W  operands to the multiplier; held stable while mul_start is high
- mul_done  in  1  multiplier completion flag
- mul_y  in  2*W  multiplier product
- busy  out  1  high whenever state is not IDLE
- ops_cnt  out  16  count of completed responses, including errors; wraps at 0xFFFF→0

## Operation

- FSM states: IDLE, RUN, RESP.
- IDLE:
  - If any req_valid is high, the winner g is the first requester with req_valid set, searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[g] is asserted combinationally in the same cycle.
  - At the clock edge the block captures req_a[g], req_b[g] and owner=g, sets last_grant=g, clears run_cnt and moves to RUN.
  - With no requests, req_ready is 0.
- RUN:
  - mul_start=1; mul_a and mul_b come from the captured registers.
  - run_cnt increments every cycle.
  - mul_done is qualified only when run_cnt >= DONE_MASK, which rejects a stale done left over from the previous operation.
  - On a qualified done: capture mul_y into rsp_y, clear err, go to RESP.
  - Else, if run_cnt == TIMEOUT-1: set rsp_y=0 and err=1, go to RESP.
  - A qualified done takes priority over the timeout in the same cycle.
- RESP:
  - mul_start=0; rsp_valid[owner]=1 with rsp_y and rsp_err.
  - Holds until rsp_ready[owner] is high. Then ops_cnt increments and the FSM returns to IDLE.
  - rsp_ready on other lines is ignored.
  - RESP lasts at least 1 cycle, so mul_start is low for at least 1 cycle between operations; the multiplier re-arms on that cycle.
- req_valid from a non-granted requester may stay high indefinitely; it has no effect until that requester is granted.
- A requester whose response is pending may raise a new req_valid; it is only considered once the FSM is back in IDLE.
- Operands are the full unsigned W-bit values; no truncation of the 2*W product.

## Timing

- Reset values: state=IDLE, last_grant=NREQ-1 (requester 0 has first priority), req_ready=0, rsp_valid=0, rsp_y=0, rsp_err=0, mul_start=0, mul_a=0, mul_b=0, busy=0, ops_cnt=0.
- Handshake accepted in cycle T:
  - mul_start is high from T+1.
  - If mul_done is first qualified in cycle T+1+N, rsp_valid is high from T+2+N.
  - If rsp_ready is already high at T+2+N, the FSM is back in IDLE at T+3+N.
  - The earliest next grant is therefore cycle T+3+N.
- Timeout: rsp_valid with rsp_err=1 is high from T+1+TIMEOUT.
- Reset asserted mid-RUN or mid-RESP:
  - All state returns immediately to reset values.
  - mul_start drops asynchronously.
  - The in-flight operation is lost with no response.
- Maximum throughput: one operation per N+3 cycles.

## Test plan

- Single op: requester 0, a=3, b=5; multiplier model has N=17 → rsp_valid[0] at T+19, rsp_y=15, rsp_err=0, ops_cnt=1.
- Full-scale: a=0xFFFF, b=0xFFFF → rsp_y=0xFFFE0001; a=0, b=0x1234 → rsp_y=0.
- Round-robin: all four req_valid held high with distinct operands → grant order 0,1,2,3,0; each rsp_valid goes only to its owner with the correct product.
- Backpressure: rsp_ready[owner] held low for 10 cycles → rsp_valid and rsp_y stable, mul_start=0, no new req_ready during that time; ops_cnt increments once on acceptance.
- Timeout and stale done:
  - Model never raises done → rsp_err=1, rsp_y=0 at T+1+TIMEOUT.
  - Model holds done high at the start of RUN → ignored for DONE_MASK cycles; result is taken from the first qualified done.
- Reset mid-RUN: rst_n low at T+5 → mul_start=0 and busy=0 immediately; after release, a new request to requester 0 completes normally and ops_cnt=1.
